// File: rtl/wb_trace_capture.sv
// Small FIFO with async reset and flush; storage is registered, head readable in the cycle it becomes valid.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module wb_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
)(
   input  logic             CLK,
   input  logic             RST_ASYNC,
   input  logic             flush,
   input  logic             pushVld,
   input  logic [WIDTH-1:0] pushDat,
   input  logic             popRdy,
   output logic             popVld,
   output logic [WIDTH-1:0] popDat,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic             full;
   logic             doPush;
   logic             doPop;

   assign popVld = (count != '0);
   assign full   = (count == (AW+1)'(DEPTH));
   assign doPop  = popVld & popRdy;
   assign doPush = pushVld & (~full | doPop);
   assign popDat = mem[rdPtr];

   // Storage is reset too, so the record fields read as zero out of reset.
   always_ff @(posedge CLK or posedge RST_ASYNC) begin
      if (RST_ASYNC) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            mem[wrPtr] <= pushDat;
            wrPtr      <= wrPtr + AW'(1);
         end
         if (doPop) rdPtr <= rdPtr + AW'(1);
         count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
      end
   end

endmodule

// Passive Wishbone B4 pipelined monitor: pairs address and data phases into trace records, flags violations.
// Record valid the cycle after its data phase; never stalls the bus, records hitting a full FIFO are counted and lost.
module wb_trace_capture #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH = 8,
   parameter int OUT_DEPTH = 4,
   parameter int TIMEOUT = 256,
   localparam int SEL_W = DATA_W/8,
   localparam int CNT_W = $clog2(DEPTH)+1
)(
   input  logic              CLK,
   input  logic              RST_ASYNC,
   input  logic [ADDR_W-1:0] WB_ADR_IN,
   input  logic [DATA_W-1:0] WB_DAT_WR_IN,
   input  logic [DATA_W-1:0] WB_DAT_RD_IN,
   input  logic              WB_CYC_IN,
   input  logic              WB_STB_IN,
   input  logic              WB_WE_IN,
   input  logic              WB_STALL_IN,
   input  logic              WB_ACK_IN,
   input  logic              WB_ERR_IN,
   input  logic [SEL_W-1:0]  WB_SEL_IN,
   input  logic              CLR_IN,
   output logic              TRC_VALID_OUT,
   input  logic              TRC_READY_IN,
   output logic [ADDR_W-1:0] TRC_ADR_OUT,
   output logic [DATA_W-1:0] TRC_DAT_OUT,
   output logic [SEL_W-1:0]  TRC_SEL_OUT,
   output logic              TRC_WE_OUT,
   output logic              TRC_ERR_OUT,
   output logic [15:0]       TRC_LAT_OUT,
   output logic [CNT_W-1:0]  OUTSTANDING_OUT,
   output logic              ERR_ORPHAN_OUT,
   output logic              ERR_OVERFLOW_OUT,
   output logic              ERR_TIMEOUT_OUT,
   output logic              ERR_ABORT_OUT,
   output logic [15:0]       DROP_CNT_OUT
);

   localparam int OCNT_W = $clog2(OUT_DEPTH)+1;
   localparam int TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;

   typedef struct packed {
      logic [ADDR_W-1:0] adr;
      logic              we;
      logic [SEL_W-1:0]  sel;
      logic [DATA_W-1:0] dat;
      logic [15:0]       ts;
   } req_t;

   typedef struct packed {
      logic [ADDR_W-1:0] adr;
      logic [DATA_W-1:0] dat;
      logic [SEL_W-1:0]  sel;
      logic              we;
      logic              err;
      logic [15:0]       lat;
   } rec_t;

   req_t              reqIn, reqHead, pairSrc;
   rec_t              recIn, recHead;
   logic              aStb, dStb;
   logic              reqVld, reqEmpty, reqFull, reqPush, reqFlush;
   logic              recVld, recFull, recPush, recDrop;
   logic [CNT_W-1:0]  reqCnt;
   logic [OCNT_W-1:0] recCnt;
   logic              cycQ;
   logic [15:0]       tsCnt;
   logic [TMO_W-1:0]  tmoCnt, tmoNext;
   logic              tmoHit;

   assign aStb     = WB_CYC_IN & WB_STB_IN & ~WB_STALL_IN;
   assign dStb     = WB_CYC_IN & (WB_ACK_IN | WB_ERR_IN);
   assign reqEmpty = ~reqVld;
   assign reqFull  = (reqCnt == CNT_W'(DEPTH));
   // Same-cycle address and data phase on an empty queue pairs directly and never enters the queue.
   assign reqPush  = aStb & ~(dStb & reqEmpty);
   assign reqFlush = cycQ & ~WB_CYC_IN & ~reqEmpty;
   assign recPush  = dStb & (aStb | ~reqEmpty);
   assign recFull  = (recCnt == OCNT_W'(OUT_DEPTH));
   assign recDrop  = recPush & recFull & ~(recVld & TRC_READY_IN);

   always_comb begin
      reqIn.adr   = WB_ADR_IN;
      reqIn.we    = WB_WE_IN;
      reqIn.sel   = WB_SEL_IN;
      reqIn.dat   = WB_DAT_WR_IN;
      reqIn.ts    = tsCnt;
      pairSrc     = reqEmpty ? reqIn : reqHead;
      recIn.adr   = pairSrc.adr;
      recIn.dat   = pairSrc.we ? pairSrc.dat : WB_DAT_RD_IN;
      recIn.sel   = pairSrc.sel;
      recIn.we    = pairSrc.we;
      recIn.err   = WB_ERR_IN;
      recIn.lat   = tsCnt - pairSrc.ts;
   end

   wb_trace_fifo #(.WIDTH($bits(req_t)), .DEPTH(DEPTH)) reqFifo (
      .CLK(CLK), .RST_ASYNC(RST_ASYNC), .flush(reqFlush),
      .pushVld(reqPush), .pushDat(reqIn),
      .popRdy(dStb), .popVld(reqVld), .popDat(reqHead),
      .count(reqCnt)
   );

   wb_trace_fifo #(.WIDTH($bits(rec_t)), .DEPTH(OUT_DEPTH)) recFifo (
      .CLK(CLK), .RST_ASYNC(RST_ASYNC), .flush(1'b0),
      .pushVld(recPush), .pushDat(recIn),
      .popRdy(TRC_READY_IN), .popVld(recVld), .popDat(recHead),
      .count(recCnt)
   );

   // Watchdog on the oldest request: holds at TIMEOUT rather than dropping the entry.
   always_comb begin
      tmoNext = tmoCnt;
      if (dStb | reqEmpty | reqFlush)
         tmoNext = '0;
      else if (TIMEOUT != 0 && tmoCnt != TMO_W'(TIMEOUT))
         tmoNext = tmoCnt + TMO_W'(1);
      tmoHit = (TIMEOUT != 0) && (tmoNext == TMO_W'(TIMEOUT));
   end

   always_ff @(posedge CLK or posedge RST_ASYNC) begin
      if (RST_ASYNC) begin
         cycQ             <= 1'b0;
         tsCnt            <= '0;
         tmoCnt           <= '0;
         ERR_ORPHAN_OUT   <= 1'b0;
         ERR_OVERFLOW_OUT <= 1'b0;
         ERR_TIMEOUT_OUT  <= 1'b0;
         ERR_ABORT_OUT    <= 1'b0;
         DROP_CNT_OUT     <= '0;
      end else begin
         cycQ   <= WB_CYC_IN;
         tsCnt  <= tsCnt + 16'd1;
         tmoCnt <= tmoNext;
         ERR_ORPHAN_OUT   <= (dStb & reqEmpty & ~aStb)  | (ERR_ORPHAN_OUT & ~CLR_IN);
         ERR_OVERFLOW_OUT <= (aStb & ~dStb & reqFull)   | (ERR_OVERFLOW_OUT & ~CLR_IN);
         ERR_TIMEOUT_OUT  <= tmoHit                     | (ERR_TIMEOUT_OUT & ~CLR_IN);
         ERR_ABORT_OUT    <= reqFlush                   | (ERR_ABORT_OUT & ~CLR_IN);
         if (CLR_IN)
            DROP_CNT_OUT <= {15'd0, recDrop};
         else if (recDrop && DROP_CNT_OUT != 16'hFFFF)
            DROP_CNT_OUT <= DROP_CNT_OUT + 16'd1;
      end
   end

   assign TRC_VALID_OUT   = recVld;
   assign TRC_ADR_OUT     = recHead.adr;
   assign TRC_DAT_OUT     = recHead.dat;
   assign TRC_SEL_OUT     = recHead.sel;
   assign TRC_WE_OUT      = recHead.we;
   assign TRC_ERR_OUT     = recHead.err;
   assign TRC_LAT_OUT     = recHead.lat;
   assign OUTSTANDING_OUT = reqCnt;

endmodule

// File: tb/tb_wb_trace_capture.sv
// Directed scenarios plus a randomized run against a queue-based transaction model of the monitor.
module tb_wb_trace_capture;

   localparam int DEPTH = 8;
   localparam int OUT_DEPTH = 4;
   localparam int TMO = 16;

   logic        CLK = 1'b0;
   logic        RST_ASYNC;
   logic [31:0] WB_ADR_IN, WB_DAT_WR_IN, WB_DAT_RD_IN;
   logic        WB_CYC_IN, WB_STB_IN, WB_WE_IN, WB_STALL_IN, WB_ACK_IN, WB_ERR_IN;
   logic [3:0]  WB_SEL_IN;
   logic        CLR_IN, TRC_VALID_OUT, TRC_READY_IN;
   logic [31:0] TRC_ADR_OUT, TRC_DAT_OUT;
   logic [3:0]  TRC_SEL_OUT;
   logic        TRC_WE_OUT, TRC_ERR_OUT;
   logic [15:0] TRC_LAT_OUT;
   logic [3:0]  OUTSTANDING_OUT;
   logic        ERR_ORPHAN_OUT, ERR_OVERFLOW_OUT, ERR_TIMEOUT_OUT, ERR_ABORT_OUT;
   logic [15:0] DROP_CNT_OUT;

   wb_trace_capture #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .OUT_DEPTH(OUT_DEPTH), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST_ASYNC(RST_ASYNC),
      .WB_ADR_IN(WB_ADR_IN), .WB_DAT_WR_IN(WB_DAT_WR_IN), .WB_DAT_RD_IN(WB_DAT_RD_IN),
      .WB_CYC_IN(WB_CYC_IN), .WB_STB_IN(WB_STB_IN), .WB_WE_IN(WB_WE_IN), .WB_STALL_IN(WB_STALL_IN),
      .WB_ACK_IN(WB_ACK_IN), .WB_ERR_IN(WB_ERR_IN), .WB_SEL_IN(WB_SEL_IN), .CLR_IN(CLR_IN),
      .TRC_VALID_OUT(TRC_VALID_OUT), .TRC_READY_IN(TRC_READY_IN),
      .TRC_ADR_OUT(TRC_ADR_OUT), .TRC_DAT_OUT(TRC_DAT_OUT), .TRC_SEL_OUT(TRC_SEL_OUT),
      .TRC_WE_OUT(TRC_WE_OUT), .TRC_ERR_OUT(TRC_ERR_OUT), .TRC_LAT_OUT(TRC_LAT_OUT),
      .OUTSTANDING_OUT(OUTSTANDING_OUT), .ERR_ORPHAN_OUT(ERR_ORPHAN_OUT),
      .ERR_OVERFLOW_OUT(ERR_OVERFLOW_OUT), .ERR_TIMEOUT_OUT(ERR_TIMEOUT_OUT),
      .ERR_ABORT_OUT(ERR_ABORT_OUT), .DROP_CNT_OUT(DROP_CNT_OUT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        err;
      int          ts;
      logic [15:0] lat;
   } ent_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic bus(input logic c, input logic s, input logic we, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] wd, input logic ack,
                      input logic err, input logic [31:0] rd);
      WB_CYC_IN = c; WB_STB_IN = s; WB_WE_IN = we; WB_ADR_IN = adr; WB_SEL_IN = sel;
      WB_DAT_WR_IN = wd; WB_ACK_IN = ack; WB_ERR_IN = err; WB_DAT_RD_IN = rd; WB_STALL_IN = 1'b0;
   endtask

   task automatic idle(input logic c);
      bus(c, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic popRec(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we, input logic err, input logic [15:0] lat);
      chk({tag, ".valid"}, TRC_VALID_OUT, 1'b1);
      chk({tag, ".adr"}, TRC_ADR_OUT, adr);
      chk({tag, ".dat"}, TRC_DAT_OUT, dat);
      chk({tag, ".sel"}, TRC_SEL_OUT, sel);
      chk({tag, ".we"}, TRC_WE_OUT, we);
      chk({tag, ".err"}, TRC_ERR_OUT, err);
      chk({tag, ".lat"}, TRC_LAT_OUT, lat);
      TRC_READY_IN = 1'b1;
      tick();
      TRC_READY_IN = 1'b0;
   endtask

   task automatic zeroOut(input string tag);
      chk({tag, ".valid"}, TRC_VALID_OUT, 1'b0);
      chk({tag, ".adr"}, TRC_ADR_OUT, 32'h0);
      chk({tag, ".dat"}, TRC_DAT_OUT, 32'h0);
      chk({tag, ".sel"}, TRC_SEL_OUT, 4'h0);
      chk({tag, ".we_err"}, {TRC_WE_OUT, TRC_ERR_OUT}, 2'b00);
      chk({tag, ".lat"}, TRC_LAT_OUT, 16'h0);
      chk({tag, ".outst"}, OUTSTANDING_OUT, 4'h0);
      chk({tag, ".flags"}, {ERR_ORPHAN_OUT, ERR_OVERFLOW_OUT, ERR_TIMEOUT_OUT, ERR_ABORT_OUT}, 4'h0);
      chk({tag, ".drop"}, DROP_CNT_OUT, 16'h0);
   endtask

   task automatic pulseClr();
      CLR_IN = 1'b1;
      tick();
      CLR_IN = 1'b0;
   endtask

   ent_t pend[$];
   ent_t expq[$];
   int   drops = 0;
   int   outst;
   int   peak;

   initial begin
      RST_ASYNC = 1'b1; CLR_IN = 1'b0; TRC_READY_IN = 1'b0;
      idle(1'b0);
      tick(); tick();
      zeroOut("reset");
      RST_ASYNC = 1'b0;
      tick();

      // single-cycle write, bypass path
      bus(1, 1, 1, 32'h1000, 4'hF, 32'hDEADBEEF, 1, 0, 0);
      tick();
      idle(1'b0);
      chk("single.outst", OUTSTANDING_OUT, 4'd0);
      popRec("single", 32'h1000, 32'hDEADBEEF, 4'hF, 1, 0, 16'd0);
      chk("single.drained", TRC_VALID_OUT, 1'b0);
      chk("single.noabort", ERR_ABORT_OUT, 1'b0);

      // pipelined reads, responses three cycles after each address phase
      outst = 0; peak = 0;
      for (int k = 0; k < 7; k++) begin
         bus(1, k < 4, 0, 32'(4 * k), 4'hF, 32'h0, k >= 3, 0, (k >= 3) ? 32'(32'h11 * (k - 2)) : 32'h0);
         tick();
         outst = outst + ((k < 4) ? 1 : 0) - ((k >= 3) ? 1 : 0);
         chk("pipe.outst", OUTSTANDING_OUT, outst);
         if (int'(OUTSTANDING_OUT) > peak) peak = int'(OUTSTANDING_OUT);
      end
      idle(1'b1);
      chk("pipe.peak", peak, 3);
      for (int i = 0; i < 4; i++)
         popRec("pipe", 32'(4 * i), 32'(32'h11 * (i + 1)), 4'hF, 0, 0, 16'd3);
      chk("pipe.drained", TRC_VALID_OUT, 1'b0);

      // overflow then orphan
      for (int i = 0; i < 9; i++) begin
         bus(1, 1, 0, 32'(32'h100 + 4 * i), 4'hF, 32'h0, 0, 0, 0);
         tick();
         if (i == 7) chk("ovf.before", {ERR_OVERFLOW_OUT, OUTSTANDING_OUT}, {1'b0, 4'd8});
      end
      chk("ovf.flag", ERR_OVERFLOW_OUT, 1'b1);
      chk("ovf.outst", OUTSTANDING_OUT, 4'd8);
      TRC_READY_IN = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'(i));
         tick();
      end
      chk("orphan.before", ERR_ORPHAN_OUT, 1'b0);
      bus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0);
      tick();
      idle(1'b1);
      TRC_READY_IN = 1'b0;
      chk("orphan.flag", ERR_ORPHAN_OUT, 1'b1);
      chk("orphan.norec", TRC_VALID_OUT, 1'b0);
      chk("orphan.outst", OUTSTANDING_OUT, 4'd0);
      chk("orphan.drop", DROP_CNT_OUT, 16'd0);
      pulseClr();
      chk("clr.flags", {ERR_ORPHAN_OUT, ERR_OVERFLOW_OUT}, 2'b00);

      // backpressure with a full record FIFO
      for (int i = 0; i < 6; i++) begin
         bus(1, 1, 1, 32'(32'h2000 + 4 * i), 4'hF, 32'(32'hA0 + i), 1, 0, 0);
         tick();
      end
      idle(1'b1);
      chk("bp.drop", DROP_CNT_OUT, 16'd2);
      for (int i = 0; i < 4; i++)
         popRec("bp", 32'(32'h2000 + 4 * i), 32'(32'hA0 + i), 4'hF, 1, 0, 16'd0);
      chk("bp.drained", TRC_VALID_OUT, 1'b0);
      pulseClr();
      chk("bp.clr", DROP_CNT_OUT, 16'd0);

      // timeout then abort
      bus(1, 1, 0, 32'h3000, 4'hF, 32'h0, 0, 0, 0);
      tick();
      idle(1'b1);
      for (int i = 0; i < TMO - 1; i++) tick();
      chk("tmo.early", ERR_TIMEOUT_OUT, 1'b0);
      tick();
      chk("tmo.flag", ERR_TIMEOUT_OUT, 1'b1);
      chk("tmo.kept", OUTSTANDING_OUT, 4'd1);
      idle(1'b0);
      tick();
      chk("abort.flag", ERR_ABORT_OUT, 1'b1);
      chk("abort.outst", OUTSTANDING_OUT, 4'd0);
      chk("abort.norec", TRC_VALID_OUT, 1'b0);
      pulseClr();
      chk("abort.clr", {ERR_TIMEOUT_OUT, ERR_ABORT_OUT}, 2'b00);

      // ERR response (ACK and ERR together), then async reset with traffic in flight
      bus(1, 1, 0, 32'h4000, 4'h3, 32'h0, 1, 1, 32'hCAFE);
      tick();
      idle(1'b1);
      popRec("errrsp", 32'h4000, 32'hCAFE, 4'h3, 0, 1, 16'd0);
      bus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0);
      tick();
      bus(1, 1, 0, 32'h4004, 4'hF, 32'h0, 0, 1, 32'hBEEF);
      tick();
      for (int i = 0; i < 3; i++) begin
         bus(1, 1, 0, 32'(32'h5000 + 4 * i), 4'hF, 32'h0, 0, 0, 0);
         tick();
      end
      idle(1'b1);
      chk("prerst.state", {TRC_VALID_OUT, TRC_ERR_OUT, ERR_ORPHAN_OUT, OUTSTANDING_OUT}, {3'b111, 4'd3});
      RST_ASYNC = 1'b1;
      #1;
      zeroOut("asyncrst");
      tick();
      RST_ASYNC = 1'b0;
      bus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h0);
      tick();
      idle(1'b1);
      chk("postrst.orphan", {ERR_ORPHAN_OUT, TRC_VALID_OUT}, 2'b10);
      pulseClr();
      bus(1, 1, 1, 32'h6000, 4'hF, 32'h12345678, 0, 0, 0);
      tick();
      bus(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'hFFFF);
      tick();
      idle(1'b1);
      popRec("postrst", 32'h6000, 32'h12345678, 4'hF, 1, 0, 16'd1);

      // randomized traffic against the transaction model
      chk("rnd.start", {TRC_VALID_OUT, OUTSTANDING_OUT, DROP_CNT_OUT}, 21'h0);
      for (int n = 0; n < 800; n++) begin
         ent_t cur, r;
         logic s, st, a, d, e, rdy, byp;
         logic [31:0] rd;
         cur.adr = $urandom; cur.we = 1'($urandom_range(0, 1)); cur.sel = 4'($urandom);
         cur.dat = $urandom; cur.err = 1'b0; cur.ts = cyc; cur.lat = 16'h0;
         s   = ($urandom_range(0, 3) != 0);
         st  = ($urandom_range(0, 3) == 0);
         a   = s & ~st;
         d   = (pend.size() > 0 || a) && ($urandom_range(0, 1) == 1);
         e   = d && ($urandom_range(0, 4) == 0);
         rd  = $urandom;
         rdy = ($urandom_range(0, 2) != 0);
         WB_CYC_IN = 1'b1; WB_STB_IN = s; WB_STALL_IN = st; WB_WE_IN = cur.we;
         WB_ADR_IN = cur.adr; WB_SEL_IN = cur.sel; WB_DAT_WR_IN = cur.dat; WB_DAT_RD_IN = rd;
         WB_ERR_IN = e; WB_ACK_IN = d && (!e || $urandom_range(0, 1) == 1);
         TRC_READY_IN = rdy;

         chk("rnd.valid", TRC_VALID_OUT, expq.size() != 0);
         chk("rnd.outst", OUTSTANDING_OUT, pend.size());
         if (rdy && expq.size() > 0) begin
            r = expq.pop_front();
            chk("rnd.adr", TRC_ADR_OUT, r.adr);
            chk("rnd.dat", TRC_DAT_OUT, r.dat);
            chk("rnd.sel_we_err", {TRC_SEL_OUT, TRC_WE_OUT, TRC_ERR_OUT}, {r.sel, r.we, r.err});
            chk("rnd.lat", TRC_LAT_OUT, r.lat);
         end
         byp = d && pend.size() == 0;
         if (d) begin
            r = byp ? cur : pend.pop_front();
            if (!r.we) r.dat = rd;
            r.err = e;
            r.lat = 16'(cyc - r.ts);
            if (expq.size() < OUT_DEPTH) expq.push_back(r);
            else drops++;
         end
         if (a && !byp && pend.size() < DEPTH) pend.push_back(cur);
         tick();
      end
      idle(1'b1);
      TRC_READY_IN = 1'b0;
      chk("rnd.drops", DROP_CNT_OUT, 16'(drops));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
